// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALU ops, multiplier FSM states, counter width).
package ex_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam int EX_DW = 16;
    localparam int CNT_W = $clog2(EX_DW);
endpackage

// File: rtl/ex_seq_mul.sv
// ex_seq_mul: iterative shift-add multiplier, one partial product per clock (used only when EX_MUL_EN is defined).
module ex_seq_mul
    import ex_pkg::*;
#(
    parameter int W = EX_DW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_product
);
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a, r_b, r_acc;
    // The start edge already folds in bit 0, so W-1 busy steps finish the product by cnt==0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_state <= ST_BUSY;
                r_cnt   <= CNT_W'(W - 1);
                r_acc   <= i_b[0] ? i_a : '0;
                r_a     <= i_a << 1;
                r_b     <= i_b >> 1;
            end
        end else if (r_cnt != '0) begin
            r_acc <= r_acc + (r_b[0] ? r_a : '0);
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_state <= ST_IDLE;
        end
    end
    assign o_busy    = r_state == ST_BUSY;
    assign o_done    = o_busy & (r_cnt == '0);
    assign o_product = r_acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit MIPS pipe; ALU plus optional multi-cycle MUL.
// Define EX_MUL_EN to enable the iterative multiplier and the stall output.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MID_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  validIn,
    input  logic [WIDTH-1:0]      instrIn,
    input  logic [MID_WIDTH-1:0]  midSignalIn,
    input  logic [2:0]            aluOp,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic [DATA_WIDTH-1:0] storeData,
    input  logic                  memWriteIn,
    output logic                  stall,
    output logic                  validOut,
    output logic [WIDTH-1:0]      instrOut,
    output logic [MID_WIDTH-1:0]  midSignalOut,
    output logic [DATA_WIDTH-1:0] aluResult,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  writeEn
);
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_slt;
    assign w_slt = $signed(opA) < $signed(opB);
    assign w_alu = aluOp == ALU_ADD ? opA + opB :
                   aluOp == ALU_SUB ? opA - opB :
                   aluOp == ALU_AND ? opA & opB :
                   aluOp == ALU_OR  ? opA | opB :
                   aluOp == ALU_XOR ? opA ^ opB :
                   aluOp == ALU_SLT ? {{(DATA_WIDTH-1){1'b0}}, w_slt} :
                   aluOp == ALU_SHL ? opA << opB[3:0] : '0;
`ifdef EX_MUL_EN
    logic                  w_busy, w_done, w_start;
    logic [DATA_WIDTH-1:0] w_product;
    logic [WIDTH-1:0]      r_mul_instr;
    logic [MID_WIDTH-1:0]  r_mul_mid;
    assign w_start = !w_busy & validIn & (aluOp == ALU_MUL);
    // Gated by reset so an abort drops stall at once even while a MUL is still presented.
    assign stall   = reset & (w_start | (w_busy & !w_done));
    ex_seq_mul #(.W(DATA_WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_a       (opA),
        .i_b       (opB),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_product (w_product)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_instr <= '0;
            r_mul_mid   <= '0;
        end else if (w_start) begin
            r_mul_instr <= instrIn;
            r_mul_mid   <= midSignalIn;
        end
    end
`else
    assign stall = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validOut     <= 1'b0;
            instrOut     <= '0;
            midSignalOut <= '0;
            aluResult    <= '0;
            writeData    <= '0;
            writeEn      <= 1'b0;
        end
`ifdef EX_MUL_EN
        else if (w_done) begin
            validOut     <= 1'b1;
            instrOut     <= r_mul_instr;
            midSignalOut <= r_mul_mid;
            aluResult    <= w_product;
            writeEn      <= 1'b0;
        end else if (w_start | w_busy) begin
            validOut     <= 1'b0;
            instrOut     <= '0;
            midSignalOut <= '0;
            writeEn      <= 1'b0;
        end
`endif
        else begin
            validOut     <= validIn;
            instrOut     <= validIn ? instrIn : '0;
            midSignalOut <= validIn ? midSignalIn : '0;
            writeEn      <= validIn & memWriteIn;
            if (validIn) begin
                aluResult <= w_alu;
                writeData <= storeData;
            end
        end
    end
endmodule
